// File: rtl/contador_sweep_ctrl_if.sv
// Bus between the sweep sequencer, its CSR/control side and the contador datapath.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface contador_sweep_ctrl_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned NSWEEP_W = 8
);

  // Control/CSR side
  logic                start;
  logic                abort;
  logic [NSWEEP_W-1:0] num_sweeps;
  logic                busy;
  logic                done;
  logic [NSWEEP_W-1:0] sweep_idx;
  logic                err;
  logic [7:0]          err_cnt;

  // Counter datapath side
  logic [WIDTH-1:0]    cnt_out;
  logic                cnt_load;
  logic [WIDTH-1:0]    cnt_load_val;
  logic                cnt_en;
  logic                cnt_updown;

  modport slave (
    input  start, abort, num_sweeps, cnt_out,
    output busy, done, sweep_idx, err, err_cnt,
    output cnt_load, cnt_load_val, cnt_en, cnt_updown
  );

  modport master (
    output start, abort, num_sweeps, cnt_out,
    input  busy, done, sweep_idx, err, err_cnt,
    input  cnt_load, cnt_load_val, cnt_en, cnt_updown
  );

endinterface

// File: rtl/contador_sweep_ctrl.sv
// Sweep sequencer for the contador up/down counter: loads 0, then drives a programmed
// number of alternating full up/down sweeps while checking cnt_out against an
// internal expected value.
// Optional build macro SWEEP_CHECK_EN: when defined, the cnt_out comparator and the
// err / err_cnt registers are built; otherwise err and err_cnt are tied to 0.
module contador_sweep_ctrl #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned NSWEEP_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  contador_sweep_ctrl_if.slave  bus
);

  localparam int unsigned ERRCNT_W = 8;
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    exp_q, exp_d;
  logic [NSWEEP_W-1:0] nsw_q, nsw_d;
  logic [NSWEEP_W-1:0] sweep_idx_q, sweep_idx_d;
  logic                cnt_load_q, cnt_load_d;
  logic                cnt_en_q, cnt_en_d;
  logic                cnt_updown_q, cnt_updown_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                last_cur_c;
  logic                last_next_c;

  // Next-state / sequencing; registered outputs are decoded from the next state.
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    nsw_d        = nsw_q;
    sweep_idx_d  = sweep_idx_q;
    cnt_load_d   = 1'b0;
    cnt_en_d     = 1'b0;
    cnt_updown_d = 1'b1;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    last_cur_c   = (NSWEEP_W'(sweep_idx_q + NSWEEP_W'(1)) == nsw_q);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.num_sweeps != '0) begin
            nsw_d       = bus.num_sweeps;
            sweep_idx_d = '0;
            state_d     = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          exp_d   = '0;
          state_d = S_UP;
        end
      end
      S_UP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (exp_q != MAX) begin
          exp_d = exp_q + WIDTH'(1);
        end else begin
          sweep_idx_d = NSWEEP_W'(sweep_idx_q + NSWEEP_W'(1));
          if (last_cur_c) begin
            state_d = S_DONE;
          end else begin
            exp_d   = MAX - WIDTH'(1);
            state_d = S_DOWN;
          end
        end
      end
      S_DOWN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (exp_q != '0) begin
          exp_d = exp_q - WIDTH'(1);
        end else begin
          sweep_idx_d = NSWEEP_W'(sweep_idx_q + NSWEEP_W'(1));
          if (last_cur_c) begin
            state_d = S_DONE;
          end else begin
            exp_d   = WIDTH'(1);
            state_d = S_UP;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The turn-around cycle of a sweep is the last one when the sweep about to
    // complete brings the index up to the latched request.
    last_next_c = (NSWEEP_W'(sweep_idx_d + NSWEEP_W'(1)) == nsw_d);
    cnt_load_d  = (state_d == S_LOAD);
    busy_d      = (state_d == S_LOAD) || (state_d == S_UP) || (state_d == S_DOWN);
    done_d      = (state_d == S_DONE);
    if (state_d == S_UP) begin
      if (exp_d != MAX) begin
        cnt_en_d     = 1'b1;
        cnt_updown_d = 1'b1;
      end else if (!last_next_c) begin
        cnt_en_d     = 1'b1;
        cnt_updown_d = 1'b0;
      end
    end else if (state_d == S_DOWN) begin
      cnt_updown_d = 1'b0;
      if (exp_d != '0) begin
        cnt_en_d = 1'b1;
      end else if (!last_next_c) begin
        cnt_en_d     = 1'b1;
        cnt_updown_d = 1'b1;
      end
    end
  end

  // State, expected value and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      exp_q        <= '0;
      nsw_q        <= '0;
      sweep_idx_q  <= '0;
      cnt_load_q   <= 1'b0;
      cnt_en_q     <= 1'b0;
      cnt_updown_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      nsw_q        <= nsw_d;
      sweep_idx_q  <= sweep_idx_d;
      cnt_load_q   <= cnt_load_d;
      cnt_en_q     <= cnt_en_d;
      cnt_updown_q <= cnt_updown_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef SWEEP_CHECK_EN
  logic                err_q, err_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  // Comparator: flag any cycle in a sweep where the counter disagrees with exp.
  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if ((state_q == S_IDLE) && bus.start && (bus.num_sweeps != '0)) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else if (((state_q == S_UP) || (state_q == S_DOWN)) && (bus.cnt_out != exp_q)) begin
      err_d = 1'b1;
      if (err_cnt_q != {ERRCNT_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + ERRCNT_W'(1);
      end
    end
  end

  // Error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
`else
  logic unused_cnt_out;
  assign unused_cnt_out = ^bus.cnt_out;
  assign bus.err        = 1'b0;
  assign bus.err_cnt    = '0;
`endif

  assign bus.cnt_load     = cnt_load_q;
  assign bus.cnt_load_val = '0;
  assign bus.cnt_en       = cnt_en_q;
  assign bus.cnt_updown   = cnt_updown_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.sweep_idx    = sweep_idx_q;

endmodule
